video_timing_gen: RTL and testbench

- Raster timing source for the HDMI output path; sits directly upstream of the three TMDS channel encoders.
- Counts pixel clocks into horizontal/vertical positions and issues an early pixel request with X/Y to the frame-buffer reader.
- Issues DE, HSYNC and VSYNC delayed by a programmable pipeline depth, aligned with the returned pixel data.
- HSYNC/VSYNC drive C0/C1 of the blue-channel encoder.

---
 rtl/video_timing_pkg.sv | 34 +++
 rtl/vtg_delay_line.sv | 30 +++
 rtl/video_timing_gen.sv | 122 ++++++++++++
 tb/tb_video_timing_gen.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: standard raster timings, counter width and colour-bar palette
package video_timing_pkg;

    localparam int CNT_W = 12;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam logic VGA_HS_POL = 1'b0;
    localparam logic VGA_VS_POL = 1'b0;

    localparam int HD720_H_ACTIVE = 1280;
    localparam int HD720_H_FP     = 110;
    localparam int HD720_H_SYNC   = 40;
    localparam int HD720_H_BP     = 220;
    localparam int HD720_V_ACTIVE = 720;
    localparam int HD720_V_FP     = 5;
    localparam int HD720_V_SYNC   = 5;
    localparam int HD720_V_BP     = 20;
    localparam logic HD720_HS_POL = 1'b1;
    localparam logic HD720_VS_POL = 1'b1;

    // index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [7:0][23:0] BAR_RGB = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

endpackage

// File: rtl/vtg_delay_line.sv
// vtg_delay_line: W-bit shift register of depth D with synchronous reset-to-value
module vtg_delay_line #(
    parameter int W = 3,
    parameter int D = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         CK,
    input  logic         RESET,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (D == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = CK ^ RESET;
            assign q = d;
        end else begin : g_sr
            logic [D-1:0][W-1:0] sr;
            always_ff @(posedge CK)
                if (RESET) sr <= {D{RST_VAL}};
                else begin
                    sr[0] <= d;
                    for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
                end
            assign q = sr[D-1];
        end
    endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters, early pixel request and delayed DE/HSYNC/VSYNC (colour bars with VTG_COLORBAR_EN)
module video_timing_gen import video_timing_pkg::*; #(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic HS_POL   = VGA_HS_POL,
    parameter logic VS_POL   = VGA_VS_POL,
    parameter int   PIPE_DLY = 2
) (
    input  logic        CK,
    input  logic        RESET,
    output logic        REQ,
    output logic [11:0] X,
    output logic [11:0] Y,
    output logic        FRAME_START,
    output logic        DE,
    output logic        HSYNC,
    output logic        VSYNC
`ifdef VTG_COLORBAR_EN
    ,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B
`endif
);

    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             hs_i, vs_i;
    logic             h_last, v_last, active;

    assign h_last = h_cnt == H_LAST;
    assign v_last = v_cnt == V_LAST;
    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);

    // hs_i/vs_i carry the output polarity so the delay line resets to idle levels
    always_ff @(posedge CK)
        if (RESET) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            REQ         <= 1'b0;
            X           <= '0;
            Y           <= '0;
            FRAME_START <= 1'b0;
            hs_i        <= ~HS_POL;
            vs_i        <= ~VS_POL;
        end else begin
            h_cnt       <= h_last ? '0 : h_cnt + 1'b1;
            if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            REQ         <= active;
            if (active) begin
                X <= h_cnt;
                Y <= v_cnt;
            end
            FRAME_START <= (h_cnt == '0) && (v_cnt == '0);
            hs_i        <= (h_cnt >= HS_BEG && h_cnt < HS_END) ? HS_POL : ~HS_POL;
            vs_i        <= (v_cnt >= VS_BEG && v_cnt < VS_END) ? VS_POL : ~VS_POL;
        end

`ifdef VTG_COLORBAR_EN
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int DW    = 27;
    localparam logic [DW-1:0] DLY_RST = {1'b0, ~HS_POL, ~VS_POL, 24'h0};

    logic [CNT_W-1:0] sub_cnt;
    logic [2:0]       bar;
    logic [23:0]      rgb_i;

    // bar/sub_cnt track h_cnt; bar may wrap in blanking, where rgb_i is forced to 0
    always_ff @(posedge CK)
        if (RESET) begin
            sub_cnt <= '0;
            bar     <= '0;
            rgb_i   <= '0;
        end else begin
            rgb_i <= active ? BAR_RGB[bar] : 24'h0;
            if (h_last) begin
                sub_cnt <= '0;
                bar     <= '0;
            end else if (sub_cnt == CNT_W'(BAR_W - 1)) begin
                sub_cnt <= '0;
                bar     <= bar + 1'b1;
            end else sub_cnt <= sub_cnt + 1'b1;
        end

    logic [DW-1:0] dly_d, dly_q;
    assign dly_d = {REQ, hs_i, vs_i, rgb_i};
    assign {DE, HSYNC, VSYNC, R, G, B} = dly_q;
`else
    localparam int DW = 3;
    localparam logic [DW-1:0] DLY_RST = {1'b0, ~HS_POL, ~VS_POL};

    logic [DW-1:0] dly_d, dly_q;
    assign dly_d = {REQ, hs_i, vs_i};
    assign {DE, HSYNC, VSYNC} = dly_q;
`endif

    vtg_delay_line #(
        .W      (DW),
        .D      (PIPE_DLY),
        .RST_VAL(DLY_RST)
    ) u_dly (
        .CK   (CK),
        .RESET(RESET),
        .d    (dly_d),
        .q    (dly_q)
    );

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: checks two delay depths against a position-from-cycle-count raster model
module tb_video_timing_gen;

`ifdef VTG_COLORBAR_EN
    localparam int HA = 8;
`else
    localparam int HA = 4;
`endif
    localparam int HF = 1, HSW = 2, HB = 1;
    localparam int VA = 3, VF = 1, VSW = 1, VB = 1;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FT = HT * VT;

    logic CK = 1'b0;
    logic RESET = 1'b1;

    logic        req2, fs2, de2, hs2, vs2;
    logic [11:0] x2, y2;
    logic        req0, fs0, de0, hs0, vs0;
    logic [11:0] x0, y0;
`ifdef VTG_COLORBAR_EN
    logic [7:0] r2, g2, b2, r0, g0, b0;
`endif

    always #5 CK = ~CK;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(2)
    ) dut2 (
        .CK(CK), .RESET(RESET), .REQ(req2), .X(x2), .Y(y2),
        .FRAME_START(fs2), .DE(de2), .HSYNC(hs2), .VSYNC(vs2)
`ifdef VTG_COLORBAR_EN
        , .R(r2), .G(g2), .B(b2)
`endif
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(0)
    ) dut0 (
        .CK(CK), .RESET(RESET), .REQ(req0), .X(x0), .Y(y0),
        .FRAME_START(fs0), .DE(de0), .HSYNC(hs0), .VSYNC(vs0)
`ifdef VTG_COLORBAR_EN
        , .R(r0), .G(g0), .B(b0)
`endif
    );

    int checks = 0;
    int errors = 0;
    int k = -1;
    int ex = 0, ey = 0;
    int last_fs = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at k=%0d: got %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    // n = pixel-clock index since reset release (negative: nothing emitted yet)
    function automatic void pos(input int n, output logic a, output logic hs, output logic vs,
                                output logic f, output int hh, output int vv);
        int p;
        if (n < 0) begin
            a = 0; hs = 0; vs = 0; f = 0; hh = 0; vv = 0;
        end else begin
            p  = n % FT;
            hh = p % HT;
            vv = p / HT;
            a  = hh < HA && vv < VA;
            hs = hh >= HA + HF && hh < HA + HF + HSW;
            vs = vv >= VA + VF && vv < VA + VF + VSW;
            f  = p == 0;
        end
    endfunction

    function automatic logic [23:0] bar_color(input logic a, input int hh);
        int bar;
        logic [7:0] r, g, b;
        bar = hh / (HA / 8 > 0 ? HA / 8 : 1);
        r = (bar == 0 || bar == 1 || bar == 4 || bar == 5) ? 8'hFF : 8'h00;
        g = (bar <= 3) ? 8'hFF : 8'h00;
        b = (bar % 2 == 0 && bar < 7) ? 8'hFF : 8'h00;
        return a ? {r, g, b} : 24'h0;
    endfunction

    task automatic check_all();
        logic a, hs, vs, f;
        int hh, vv;
        pos(k, a, hs, vs, f, hh, vv);
        if (k < 0) begin
            ex = 0; ey = 0; last_fs = -1;
        end else if (a) begin
            ex = hh; ey = vv;
        end
        chk("REQ", req2, a);
        chk("X", x2, ex);
        chk("Y", y2, ey);
        chk("FRAME_START", fs2, f);
        chk("REQ_D0", req0, a);
        chk("X_D0", x0, ex);
        chk("Y_D0", y0, ey);
        chk("DE_D0", de0, a);
        chk("HSYNC_D0", hs0, hs);
        chk("VSYNC_D0", vs0, vs);
`ifdef VTG_COLORBAR_EN
        chk("RGB_D0", {r0, g0, b0}, bar_color(a, hh));
`endif
        if (fs2 === 1'b1) begin
            if (last_fs >= 0) chk("FS_PERIOD", k - last_fs, FT);
            last_fs = k;
        end
        pos(k < 0 ? -1 : k - 2, a, hs, vs, f, hh, vv);
        chk("DE", de2, a);
        chk("HSYNC", hs2, hs);
        chk("VSYNC", vs2, vs);
`ifdef VTG_COLORBAR_EN
        chk("RGB", {r2, g2, b2}, bar_color(a, hh));
`endif
    endtask

    task automatic cyc(input logic r);
        RESET = r;
        @(posedge CK);
        #1;
        k = r ? -1 : k + 1;
        check_all();
    endtask

    initial begin
        repeat (3) cyc(1'b1);
        repeat (3 * FT) cyc(1'b0);
        cyc(1'b1);
        while (k != HT + 2) cyc(1'b0);
        cyc(1'b1);
        repeat (2 * FT) cyc(1'b0);
        repeat (600) cyc($urandom_range(0, 99) < 3);
        repeat (FT + 4) cyc(1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
